// File: rtl/wb_stepper.sv
// wb_stepper: Wishbone slave that drives step/dir/enable for an external stepper driver.
// Sends a programmed number of fixed-period steps and tracks signed absolute position.
module wb_stepper #(
    parameter int PULSE_W   = 100,
    parameter int DIR_SETUP = 200,
    parameter int CNT_W     = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_we_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    output logic        wb_ack_o,
    output logic        step_o,
    output logic        dir_o,
    output logic        en_o,
    output logic        intr
);
    typedef enum logic [1:0] {IDLE, SETUP, PULSE, LOW} state_e;

    localparam logic [31:0]      MIN_PERIOD = 32'(PULSE_W + 1);
    localparam logic [CNT_W-1:0] ONE        = 1;

    state_e           state_q, state_d;
    logic             ack_q, ack_d;
    logic             dir_q, dir_d, irq_en_q, irq_en_d;
    logic             done_q, done_d, stop_q, stop_d;
    logic             dir_out_q, dir_out_d;
    logic [31:0]      period_q, period_d, pos_q, pos_d;
    logic [31:0]      timer_q, timer_d, low_len_q, low_len_d;
    logic [CNT_W-1:0] count_q, count_d, remaining_q, remaining_d;

    logic [2:0]  reg_sel;
    logic        wr_en, start_wr, stop_wr, busy, enter_pulse;
    logic [31:0] eff_period;
    logic [15:0] rem16;
    logic        bus_unused;

    assign reg_sel    = wb_adr_i[4:2];
    assign wr_en      = ack_q & wb_cyc_i & wb_stb_i & wb_we_i;
    assign start_wr   = wr_en && (reg_sel == 3'd0) && wb_dat_i[0];
    assign stop_wr    = wr_en && (reg_sel == 3'd0) && wb_dat_i[1];
    assign busy       = (state_q != IDLE);
    assign eff_period = (period_q < MIN_PERIOD) ? MIN_PERIOD : period_q;
    assign rem16      = 16'(remaining_q);
    assign bus_unused = ^{wb_sel_i, wb_adr_i[31:5], wb_adr_i[1:0]};

    assign wb_ack_o = ack_q;
    assign step_o   = (state_q == PULSE);
    assign en_o     = busy;
    assign dir_o    = dir_out_q;
    assign intr     = done_q & irq_en_q;

    always_comb begin
        wb_dat_o = '0;
        if (ack_q) begin
            case (reg_sel)
                3'd0:    wb_dat_o = {30'b0, dir_q, irq_en_q};
                3'd1:    wb_dat_o = period_q;
                3'd2:    wb_dat_o = 32'(count_q);
                3'd3:    wb_dat_o = {rem16, 14'b0, done_q, busy};
                3'd4:    wb_dat_o = pos_q;
                default: wb_dat_o = '0;
            endcase
        end
    end

    always_comb begin
        state_d     = state_q;
        ack_d       = wb_cyc_i & wb_stb_i & ~ack_q;
        dir_d       = dir_q;
        irq_en_d    = irq_en_q;
        done_d      = done_q;
        stop_d      = stop_q;
        dir_out_d   = dir_out_q;
        period_d    = period_q;
        pos_d       = pos_q;
        timer_d     = timer_q;
        low_len_d   = low_len_q;
        count_d     = count_q;
        remaining_d = remaining_q;
        enter_pulse = 1'b0;

        if (wr_en) begin
            case (reg_sel)
                3'd0: begin
                    dir_d    = wb_dat_i[2];
                    irq_en_d = wb_dat_i[3];
                end
                3'd1: period_d = wb_dat_i;
                3'd2: count_d  = wb_dat_i[CNT_W-1:0];
                3'd3: if (wb_dat_i[1]) done_d = 1'b0;
                3'd4: if (!busy) pos_d = wb_dat_i;
                default: ;
            endcase
        end

        // STOP only matters mid-run; when idle a combined START takes effect instead
        if (stop_wr && busy) stop_d = 1'b1;

        case (state_q)
            IDLE: begin
                if (start_wr) begin
                    if (count_q != '0) begin
                        state_d     = SETUP;
                        remaining_d = count_q;
                        dir_out_d   = wb_dat_i[2];
                        done_d      = 1'b0;
                        timer_d     = 32'(DIR_SETUP - 1);
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            SETUP: begin
                if (timer_q == '0) enter_pulse = 1'b1;
                else               timer_d = timer_q - 32'd1;
            end
            PULSE: begin
                if (timer_q == '0) begin
                    state_d = LOW;
                    timer_d = low_len_q;
                end else begin
                    timer_d = timer_q - 32'd1;
                end
            end
            LOW: begin
                if (timer_q != '0) begin
                    timer_d = timer_q - 32'd1;
                end else if (remaining_q == '0 || stop_d) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    stop_d  = 1'b0;
                end else begin
                    enter_pulse = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Period is latched per step so a mid-run PERIOD write lands on the next step
        if (enter_pulse) begin
            state_d     = PULSE;
            remaining_d = remaining_q - ONE;
            pos_d       = dir_out_q ? pos_q + 32'd1 : pos_q - 32'd1;
            timer_d     = 32'(PULSE_W - 1);
            low_len_d   = eff_period - 32'(PULSE_W) - 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ack_q       <= 1'b0;
            dir_q       <= 1'b0;
            irq_en_q    <= 1'b0;
            done_q      <= 1'b0;
            stop_q      <= 1'b0;
            dir_out_q   <= 1'b0;
            period_q    <= '0;
            pos_q       <= '0;
            timer_q     <= '0;
            low_len_q   <= '0;
            count_q     <= '0;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            ack_q       <= ack_d;
            dir_q       <= dir_d;
            irq_en_q    <= irq_en_d;
            done_q      <= done_d;
            stop_q      <= stop_d;
            dir_out_q   <= dir_out_d;
            period_q    <= period_d;
            pos_q       <= pos_d;
            timer_q     <= timer_d;
            low_len_q   <= low_len_d;
            count_q     <= count_d;
            remaining_q <= remaining_d;
        end
    end
endmodule
